btn_conditioner: RTL

Parametrised multi-channel push-button conditioner for the space_invaders front panel. It takes the raw asynchronous board buttons (btn_right, btn_left, btn_shoot, btn_rst, and any added later) and per channel provides:

- synchronisation;
- counter-based debounce;
- a clean debounced level;
- single-cycle press and release pulses;
- optional hold-to-repeat press pulses for movement.

It sits between the top-level button pins and the game logic, replacing ad-hoc per-button edge detection.

---
 rtl/btn_conditioner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: per channel synchroniser, counter debounce,
// clean level, single-cycle press/release pulses and optional hold-to-repeat presses.
module btn_conditioner #(
    parameter int NUM_BTNS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    input  logic [NUM_BTNS-1:0] repeat_en,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic                btn_any
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [DB_W-1:0]  DB_ONE       = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             DB_SINGLE    = (DEBOUNCE_CYCLES == 1) ? 1'b1 : 1'b0;
    localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DELAY_L  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD_L = REP_W'(REPEAT_PERIOD);

    logic [NUM_BTNS-1:0] level_next_s;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [1:0]             state_r, state_next_s;
        logic [DB_W-1:0]        cnt_r, cnt_next_s;
        logic [REP_W-1:0]       rep_r, rep_next_s;
        logic                   first_r, first_next_s;
        logic                   level_r, lvl_next_s;
        logic                   press_r, press_next_s;
        logic                   release_r, release_next_s;
        logic                   s_s;
        logic [REP_W-1:0]       rep_target_s;

        assign s_s             = sync_r[SYNC_STAGES-1];
        assign rep_target_s    = first_r ? REP_DELAY_L : REP_PERIOD_L;
        assign level_next_s[g] = lvl_next_s;
        assign btn_level[g]    = level_r;
        assign btn_press[g]    = press_r;
        assign btn_release[g]  = release_r;

        // Synchroniser chain for the raw asynchronous button.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_r <= '0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in[g]};
            end
        end

        // Debounce / repeat FSM next-state logic.
        always_comb begin
            state_next_s   = state_r;
            cnt_next_s     = cnt_r;
            rep_next_s     = rep_r;
            first_next_s   = first_r;
            lvl_next_s     = level_r;
            press_next_s   = 1'b0;
            release_next_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (s_s) begin
                        if (DB_SINGLE) begin
                            state_next_s = ST_HELD;
                            lvl_next_s   = 1'b1;
                            press_next_s = 1'b1;
                            rep_next_s   = '0;
                            first_next_s = 1'b1;
                            cnt_next_s   = '0;
                        end else begin
                            state_next_s = ST_PRESS_WAIT;
                            cnt_next_s   = DB_ONE;
                        end
                    end else begin
                        cnt_next_s = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s_s) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                    end else if (cnt_r == DB_LAST) begin
                        state_next_s = ST_HELD;
                        lvl_next_s   = 1'b1;
                        press_next_s = 1'b1;
                        rep_next_s   = '0;
                        first_next_s = 1'b1;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s = cnt_r + DB_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s_s) begin
                        if (DB_SINGLE) begin
                            state_next_s   = ST_IDLE;
                            lvl_next_s     = 1'b0;
                            release_next_s = 1'b1;
                            cnt_next_s     = '0;
                        end else begin
                            state_next_s = ST_RELEASE_WAIT;
                            cnt_next_s   = DB_ONE;
                        end
                    end else if (repeat_en[g]) begin
                        // Counter stops one short of the target, so it never wraps.
                        if ((rep_r + REP_ONE) == rep_target_s) begin
                            press_next_s = 1'b1;
                            rep_next_s   = '0;
                            first_next_s = 1'b0;
                        end else begin
                            rep_next_s = rep_r + REP_ONE;
                        end
                    end else begin
                        rep_next_s   = '0;
                        first_next_s = 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s_s) begin
                        state_next_s = ST_HELD;
                        cnt_next_s   = '0;
                    end else if (cnt_r == DB_LAST) begin
                        state_next_s   = ST_IDLE;
                        lvl_next_s     = 1'b0;
                        release_next_s = 1'b1;
                        cnt_next_s     = '0;
                    end else begin
                        cnt_next_s = cnt_r + DB_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                    rep_next_s   = '0;
                    first_next_s = 1'b1;
                    lvl_next_s   = 1'b0;
                end
            endcase
        end

        // FSM state, counters and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r   <= ST_IDLE;
                cnt_r     <= '0;
                rep_r     <= '0;
                first_r   <= 1'b1;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                state_r   <= state_next_s;
                cnt_r     <= cnt_next_s;
                rep_r     <= rep_next_s;
                first_r   <= first_next_s;
                level_r   <= lvl_next_s;
                press_r   <= press_next_s;
                release_r <= release_next_s;
            end
        end
    end

    // Aggregate level, taken from next-state levels so it lines up with btn_level.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_any <= 1'b0;
        end else begin
            btn_any <= |level_next_s;
        end
    end

endmodule
